sc_down_transition_counter0: RTL and testbench

Loadable down-counter that decrements once per high-to-low transition of an active-low event input. It is the companion of the game's up transition counter, used for the lives counter and the level countdown. It flags zero both as a level and as a one-cycle pulse, and optionally auto-reloads.

---
 rtl/sc_down_transition_counter0_pkg.sv | 22 ++
 rtl/sc_falling_edge_detector0.sv | 43 ++++
 rtl/sc_down_transition_counter0.sv | 158 +++++++++++++++
 tb/tb_sc_down_transition_counter0.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/sc_down_transition_counter0_pkg.sv
`default_nettype none
// ============================================================================
// Module  : sc_down_transition_counter0_pkg
// Purpose : Shared definitions for the down transition counter: FSM state
//           width and the state encoding (IDLE / COUNT / ZERO).
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package sc_down_transition_counter0_pkg;

    // Width of the FSM state register (also the width of the debug bus).
    localparam int c_STATE_W = 2;

    // State encoding. Encoding 2'd3 is unused and recovers to IDLE.
    typedef enum logic [c_STATE_W-1:0] {
        c_IDLE  = 2'd0,
        c_COUNT = 2'd1,
        c_ZERO  = 2'd2
    } state_e;

endpackage : sc_down_transition_counter0_pkg
`default_nettype wire

// File: rtl/sc_falling_edge_detector0.sv
`default_nettype none
// ============================================================================
// Module  : sc_falling_edge_detector0
// Purpose : Detects a 1->0 transition on an active-low event line. The
//           previous sample is registered; the fall flag is combinational
//           from the current sample, so a fall is visible in the same cycle
//           the line first reads low.
// Ports   : clk     - system clock
//           rst     - asynchronous reset, active-high (prev resets to 1)
//           i_line  - event line, idle high
//           o_fall  - high while prev == 1 and the line is currently 0
// Revision: 1.0 - initial release
// ============================================================================
module sc_falling_edge_detector0 (
    input  logic clk,
    input  logic rst,
    input  logic i_line,
    output logic o_fall
);

    logic r_prev_q;
    logic w_prev_d;

    // The previous sample simply follows the line every cycle, so a line
    // held low produces exactly one fall.
    always_comb begin
        w_prev_d = i_line;
    end

    // Reset to 1: the line is idle high, so a line that is already low
    // when reset releases still counts as one fall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prev_q <= 1'b1;
        end else begin
            r_prev_q <= w_prev_d;
        end
    end

    assign o_fall = r_prev_q & ~i_line;

endmodule : sc_falling_edge_detector0
`default_nettype wire

// File: rtl/sc_down_transition_counter0.sv
`default_nettype none
// ============================================================================
// Module  : sc_down_transition_counter0
// Purpose : Loadable down-counter decremented once per falling edge of an
//           active-low event line. Flags zero as a level and as a one-cycle
//           pulse; optionally auto-reloads from the last loaded value.
// Ports   : SC_downTRANSITIONCOUNTER0_CLOCK_50         - system clock
//           SC_downTRANSITIONCOUNTER0_RESET_InHigh     - async reset, high
//           SC_downTRANSITIONCOUNTER0_load_InLow       - sync load, low
//           SC_downTRANSITIONCOUNTER0_data_InBUS       - load value
//           SC_downTRANSITIONCOUNTER0_downcount_InLow  - event line
//           SC_downTRANSITIONCOUNTER0_data_OutBUS      - registered count
//           SC_downTRANSITIONCOUNTER0_zero_Out         - high while in ZERO
//           SC_downTRANSITIONCOUNTER0_zeroPulse_Out    - 1-cycle zero event
//           SC_downTRANSITIONCOUNTER0_state_OutBUS     - FSM state (debug)
// Revision: 1.0 - initial release
// ============================================================================
module sc_down_transition_counter0
    import sc_down_transition_counter0_pkg::*;
#(
    parameter int downTRANSITIONCOUNTER0_DATAWIDTH = 8,
    parameter int downTRANSITIONCOUNTER0_WRAP      = 0
) (
    input  logic                                        SC_downTRANSITIONCOUNTER0_CLOCK_50,
    input  logic                                        SC_downTRANSITIONCOUNTER0_RESET_InHigh,
    input  logic                                        SC_downTRANSITIONCOUNTER0_load_InLow,
    input  logic [downTRANSITIONCOUNTER0_DATAWIDTH-1:0] SC_downTRANSITIONCOUNTER0_data_InBUS,
    input  logic                                        SC_downTRANSITIONCOUNTER0_downcount_InLow,
    output logic [downTRANSITIONCOUNTER0_DATAWIDTH-1:0] SC_downTRANSITIONCOUNTER0_data_OutBUS,
    output logic                                        SC_downTRANSITIONCOUNTER0_zero_Out,
    output logic                                        SC_downTRANSITIONCOUNTER0_zeroPulse_Out,
    output logic [c_STATE_W-1:0]                        SC_downTRANSITIONCOUNTER0_state_OutBUS
);

    localparam int c_DW = downTRANSITIONCOUNTER0_DATAWIDTH;

    logic clk;
    logic rst;

    assign clk = SC_downTRANSITIONCOUNTER0_CLOCK_50;
    assign rst = SC_downTRANSITIONCOUNTER0_RESET_InHigh;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [c_DW-1:0]      r_count_q;
    logic [c_DW-1:0]      w_count_d;
    logic [c_DW-1:0]      r_reload_q;
    logic [c_DW-1:0]      w_reload_d;
    logic [c_STATE_W-1:0] r_state_q;
    logic [c_STATE_W-1:0] w_state_d;
    logic                 r_zero_q;
    logic                 w_zero_d;
    logic                 r_pulse_q;
    logic                 w_pulse_d;

    logic                 w_fall;
    logic                 w_load;
    logic                 w_load_is_zero;
    logic                 w_last_step;

    // ------------------------------------------------------------------
    // Falling-edge detection on the event line
    // ------------------------------------------------------------------
    sc_falling_edge_detector0 u_fall_det (
        .clk    (clk),
        .rst    (rst),
        .i_line (SC_downTRANSITIONCOUNTER0_downcount_InLow),
        .o_fall (w_fall)
    );

    assign w_load         = ~SC_downTRANSITIONCOUNTER0_load_InLow;
    assign w_load_is_zero = (SC_downTRANSITIONCOUNTER0_data_InBUS == '0);

    // A fall at count 1 (or the unreachable count 0 in COUNT) is the zero
    // event. Treating 0 the same way keeps the decrement from ever
    // wrapping to all-ones even if COUNT were entered with a zero count.
    assign w_last_step    = (r_count_q <= c_DW'(1));

    // ------------------------------------------------------------------
    // Next-state / datapath. Priority: load > fall > hold.
    // ------------------------------------------------------------------
    always_comb begin
        w_count_d  = r_count_q;
        w_reload_d = r_reload_q;
        w_state_d  = r_state_q;
        w_pulse_d  = 1'b0;

        if (w_load) begin
            // A fall arriving with the load is absorbed by the load.
            w_count_d  = SC_downTRANSITIONCOUNTER0_data_InBUS;
            w_reload_d = SC_downTRANSITIONCOUNTER0_data_InBUS;
            if (w_load_is_zero) begin
                w_state_d = c_ZERO;
                w_pulse_d = 1'b1;
            end else begin
                w_state_d = c_COUNT;
            end
        end else begin
            case (r_state_q)
                c_IDLE: begin
                    // Not armed yet: falls are ignored until a load.
                end
                c_COUNT: begin
                    if (w_fall) begin
                        if (w_last_step) begin
                            w_pulse_d = 1'b1;
                            if (downTRANSITIONCOUNTER0_WRAP != 0) begin
                                w_count_d = r_reload_q;
                            end else begin
                                w_count_d = '0;
                                w_state_d = c_ZERO;
                            end
                        end else begin
                            w_count_d = r_count_q - c_DW'(1);
                        end
                    end
                end
                c_ZERO: begin
                    // Terminal until the next load; count stays at 0.
                end
                default: begin
                    w_state_d = c_IDLE;
                end
            endcase
        end

        // Registered from the next state so the level lines up with the
        // state register on the same cycle.
        w_zero_d = (w_state_d == c_ZERO);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count_q  <= '0;
            r_reload_q <= '0;
            r_state_q  <= c_IDLE;
            r_zero_q   <= 1'b0;
            r_pulse_q  <= 1'b0;
        end else begin
            r_count_q  <= w_count_d;
            r_reload_q <= w_reload_d;
            r_state_q  <= w_state_d;
            r_zero_q   <= w_zero_d;
            r_pulse_q  <= w_pulse_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign SC_downTRANSITIONCOUNTER0_data_OutBUS  = r_count_q;
    assign SC_downTRANSITIONCOUNTER0_zero_Out      = r_zero_q;
    assign SC_downTRANSITIONCOUNTER0_zeroPulse_Out = r_pulse_q;
    assign SC_downTRANSITIONCOUNTER0_state_OutBUS  = r_state_q;

endmodule : sc_down_transition_counter0
`default_nettype wire

// File: tb/tb_sc_down_transition_counter0.sv
`default_nettype none
// ============================================================================
// Module  : tb_sc_down_transition_counter0
// Purpose : Self-checking bench for sc_down_transition_counter0. Two
//           instances (stop-at-zero and auto-reload) share one stimulus
//           stream and are compared every cycle against a behavioural model.
// Ports   : none
// Revision: 1.0 - initial release
// ============================================================================
module tb_sc_down_transition_counter0;

    logic       clk;
    logic       rst;
    logic       load_n;
    logic [7:0] data;
    logic       dn;

    logic [7:0] q_out [2];
    logic       z_out [2];
    logic       p_out [2];
    logic [1:0] s_out [2];

    int tests_run;
    int tests_failed;

    // Behavioural reference: index 0 = stop at zero, index 1 = auto-reload.
    int m_cnt [2];
    int m_rel [2];
    int m_st  [2];   // 0 idle, 1 counting, 2 at zero
    int m_pulse [2];
    int m_line_prev;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    sc_down_transition_counter0 #(
        .downTRANSITIONCOUNTER0_DATAWIDTH (8),
        .downTRANSITIONCOUNTER0_WRAP      (0)
    ) u_dut_stop (
        .SC_downTRANSITIONCOUNTER0_CLOCK_50        (clk),
        .SC_downTRANSITIONCOUNTER0_RESET_InHigh    (rst),
        .SC_downTRANSITIONCOUNTER0_load_InLow      (load_n),
        .SC_downTRANSITIONCOUNTER0_data_InBUS      (data),
        .SC_downTRANSITIONCOUNTER0_downcount_InLow (dn),
        .SC_downTRANSITIONCOUNTER0_data_OutBUS     (q_out[0]),
        .SC_downTRANSITIONCOUNTER0_zero_Out        (z_out[0]),
        .SC_downTRANSITIONCOUNTER0_zeroPulse_Out   (p_out[0]),
        .SC_downTRANSITIONCOUNTER0_state_OutBUS    (s_out[0])
    );

    sc_down_transition_counter0 #(
        .downTRANSITIONCOUNTER0_DATAWIDTH (8),
        .downTRANSITIONCOUNTER0_WRAP      (1)
    ) u_dut_wrap (
        .SC_downTRANSITIONCOUNTER0_CLOCK_50        (clk),
        .SC_downTRANSITIONCOUNTER0_RESET_InHigh    (rst),
        .SC_downTRANSITIONCOUNTER0_load_InLow      (load_n),
        .SC_downTRANSITIONCOUNTER0_data_InBUS      (data),
        .SC_downTRANSITIONCOUNTER0_downcount_InLow (dn),
        .SC_downTRANSITIONCOUNTER0_data_OutBUS     (q_out[1]),
        .SC_downTRANSITIONCOUNTER0_zero_Out        (z_out[1]),
        .SC_downTRANSITIONCOUNTER0_zeroPulse_Out   (p_out[1]),
        .SC_downTRANSITIONCOUNTER0_state_OutBUS    (s_out[1])
    );

    task automatic check(input string tag, input int obs, input int exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_line_prev = 1;
        for (int i = 0; i < 2; i++) begin
            m_cnt[i]   = 0;
            m_rel[i]   = 0;
            m_st[i]    = 0;
            m_pulse[i] = 0;
        end
    endtask

    // One clock of the reference, written from the counting rules:
    // a load wins, otherwise a new high-to-low step takes one life off
    // while counting; reaching zero either parks or refills.
    task automatic model_clock(input logic ld_n, input int d, input logic line);
        bit fell;
        fell = (m_line_prev == 1) && (line == 1'b0);
        m_line_prev = int'(line);
        for (int i = 0; i < 2; i++) begin
            m_pulse[i] = 0;
            if (ld_n == 1'b0) begin
                m_cnt[i] = d;
                m_rel[i] = d;
                m_st[i]  = (d == 0) ? 2 : 1;
                m_pulse[i] = (d == 0) ? 1 : 0;
            end else if (m_st[i] == 1 && fell) begin
                if (m_cnt[i] - 1 == 0) begin
                    m_pulse[i] = 1;
                    if (i == 1) begin
                        m_cnt[i] = m_rel[i];
                    end else begin
                        m_cnt[i] = 0;
                        m_st[i]  = 2;
                    end
                end else begin
                    m_cnt[i] = m_cnt[i] - 1;
                end
            end
        end
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("%s[%0d].count", tag, i), int'(q_out[i]), m_cnt[i]);
            check($sformatf("%s[%0d].state", tag, i), int'(s_out[i]), m_st[i]);
            check($sformatf("%s[%0d].zero",  tag, i), int'(z_out[i]), (m_st[i] == 2) ? 1 : 0);
            check($sformatf("%s[%0d].pulse", tag, i), int'(p_out[i]), m_pulse[i]);
        end
    endtask

    // Drive inputs away from the edge, clock once, check 1 ns later.
    task automatic step(input string tag, input logic ld_n, input logic [7:0] d,
                        input logic line);
        load_n = ld_n;
        data   = d;
        dn     = line;
        @(posedge clk);
        model_clock(ld_n, int'(d), line);
        #1;
        check_all(tag);
    endtask

    task automatic pulse_low(input string tag);
        step(tag, 1'b1, 8'd0, 1'b0);
        step(tag, 1'b1, 8'd0, 1'b1);
    endtask

    initial begin
        logic       r_ld;
        logic [7:0] r_d;
        logic       r_ln;

        tests_run    = 0;
        tests_failed = 0;
        rst    = 1'b1;
        load_n = 1'b1;
        data   = 8'd0;
        dn     = 1'b1;
        model_reset();
        #2;
        check_all("reset");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Idle line after reset: nothing moves.
        for (int i = 0; i < 10; i++) step("idle", 1'b1, 8'd0, 1'b1);
        check("idle_count_const", int'(q_out[0]), 0);

        // Load 3, three falls to zero, then a fourth that must not underflow.
        step("load3", 1'b0, 8'd3, 1'b1);
        for (int i = 0; i < 3; i++) pulse_low("fall3");
        check("zero_level_const", int'(z_out[0]), 1);
        pulse_low("fall_at_zero");
        check("no_underflow_const", int'(q_out[0]), 0);

        // Held-low line counts exactly once.
        step("load5", 1'b0, 8'd5, 1'b1);
        for (int i = 0; i < 20; i++) step("hold_low", 1'b1, 8'd0, 1'b0);
        check("hold_low_once_const", int'(q_out[0]), 4);
        step("release", 1'b1, 8'd0, 1'b1);

        // Load wins over a simultaneous fall; then load zero.
        step("load7_fall", 1'b0, 8'd7, 1'b0);
        check("load_over_fall_const", int'(q_out[0]), 7);
        step("release", 1'b1, 8'd0, 1'b1);
        step("load0", 1'b0, 8'd0, 1'b1);
        check("load0_pulse_const", int'(p_out[0]), 1);
        step("after_load0", 1'b1, 8'd0, 1'b1);

        // Auto-reload sequence (instance 1 goes 1,2,1,2,1).
        step("load2", 1'b0, 8'd2, 1'b1);
        for (int i = 0; i < 5; i++) pulse_low("wrap");
        check("wrap_final_const", int'(q_out[1]), 1);

        // Reset asserted mid-count takes effect before the next edge.
        step("load5b", 1'b0, 8'd5, 1'b1);
        pulse_low("to4");
        rst = 1'b1;
        #1;
        model_reset();
        check_all("async_rst");
        #2;
        rst = 1'b0;
        pulse_low("idle_after_rst");

        // Randomised traffic.
        for (int n = 0; n < 400; n++) begin
            r_ld = ($urandom_range(0, 9) != 0);
            r_d  = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom_range(1, 6));
            r_ln = 1'($urandom_range(0, 1));
            step("rand", r_ld, r_d, r_ln);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Hard stop in case the stimulus ever stalls.
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule : tb_sc_down_transition_counter0
`default_nettype wire
